// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, index-width helper and word/index types
//               for the bypassing register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_NREGS = 32;

    // Index width; NREGS is a power of two so this is exact.
    function automatic int calc_addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    typedef logic [calc_addr_w(DEFAULT_NREGS)-1:0] reg_idx_t;
    typedef logic [DEFAULT_WIDTH-1:0]              data_t;

endpackage
`default_nettype wire

// File: rtl/dffe_param.sv
`default_nettype none
// ============================================================================
// Module      : dffe_param
// Description : WIDTH-bit D flip-flop with enable and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module dffe_param
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass
// Description : 1W/2R register file with registered reads, write-to-read
//               bypass, optional hardwired zero register and busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int NREGS    = DEFAULT_NREGS,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = calc_addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              bset,
    input  logic [ADDR_W-1:0] bset_addr
);

    localparam logic C_ZR = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] reg_we;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             we_eff;
    logic             bset_eff;
    logic [WIDTH-1:0] rd1_d;
    logic [WIDTH-1:0] rd2_d;
    logic             busy1_d;
    logic             busy2_d;

    assign we_eff   = we   && !(C_ZR && (waddr == '0));
    assign bset_eff = bset && !(C_ZR && (bset_addr == '0));

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_regs
            assign reg_we[i] = we_eff && (waddr == ADDR_W'(i));

            dffe_param #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .clr (clr),
                .en  (reg_we[i]),
                .d   (wdata),
                .q   (regs_q[i])
            );
        end
    endgenerate

    // A new producer (bset) overrides a retiring one (write) on the same index.
    always_comb begin
        busy_d = busy_q;
        if (we_eff) begin
            busy_d[waddr] = 1'b0;
        end
        if (bset_eff) begin
            busy_d[bset_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Reads see the post-edge state: bypassed data and next-cycle busy.
    always_comb begin
        rd1_d   = regs_q[ra1];
        busy1_d = busy_d[ra1];
        if (we_eff && (ra1 == waddr)) begin
            rd1_d = wdata;
        end
        if (C_ZR && (ra1 == '0)) begin
            rd1_d   = '0;
            busy1_d = 1'b0;
        end

        rd2_d   = regs_q[ra2];
        busy2_d = busy_d[ra2];
        if (we_eff && (ra2 == waddr)) begin
            rd2_d = wdata;
        end
        if (C_ZR && (ra2 == '0)) begin
            rd2_d   = '0;
            busy2_d = 1'b0;
        end
    end

    dffe_param #(.WIDTH(WIDTH)) u_rd1 (
        .clk (clk), .clr (clr), .en (re1), .d (rd1_d), .q (rd1)
    );

    dffe_param #(.WIDTH(WIDTH)) u_rd2 (
        .clk (clk), .clr (clr), .en (re2), .d (rd2_d), .q (rd2)
    );

    dffe_param #(.WIDTH(1)) u_busy1 (
        .clk (clk), .clr (clr), .en (re1), .d (busy1_d), .q (busy1)
    );

    dffe_param #(.WIDTH(1)) u_busy2 (
        .clk (clk), .clr (clr), .en (re2), .d (busy2_d), .q (busy2)
    );

endmodule
`default_nettype wire
